// File: rtl/sc_scbc_ulpi_reg.sv
// ULPI link-side PHY register read/write engine, ULPICLK domain.
// Define SC_SCBC_ULPI_EXTREG_EN to enable extended register access (ADDR[7:6] != 0).
module sc_scbc_ulpi_reg #(
  parameter int unsigned NXT_TIMEOUT = 64
) (
  input  logic       ULPICLK,
  input  logic       ULPIRST,
  input  logic       REQ,
  input  logic       WE,
  input  logic [7:0] ADDR,
  input  logic [7:0] WDATA,
  output logic       BUSY,
  output logic       ACK,
  output logic       ERR,
  output logic [7:0] RDATA,
  input  logic       DIR,
  input  logic       NXT,
  input  logic [7:0] DATA_I,
  output logic [7:0] DATA_O,
  output logic       DATA_OE,
  output logic       STP
);

  localparam int unsigned DW       = 8;
  localparam logic [7:0]  TMO      = 8'(NXT_TIMEOUT);
  localparam logic [5:0]  EXT_CODE = 6'h2F;
`ifdef SC_SCBC_ULPI_EXTREG_EN
  localparam int unsigned AW = 8;
`else
  localparam int unsigned AW = 6;
`endif

  typedef enum logic [3:0] {
    S_IDLE, S_WAIT_BUS, S_TXCMD, S_EXTADDR, S_WDATA,
    S_STOP, S_RD_TA, S_RD_DATA, S_RD_TA2, S_DONE
  } state_t;

  state_t          r_state, w_state_n;
  logic            r_we, w_we_n;
  logic [AW-1:0]   r_addr, w_addr_n;
  logic [DW-1:0]   r_wdata, w_wdata_n;
  logic            r_busy, w_busy_n;
  logic            r_ack, w_ack_n;
  logic            r_err, w_err_n;
  logic [DW-1:0]   r_rdata, w_rdata_n;
  logic [DW-1:0]   r_rdbuf, w_rdbuf_n;
  logic [DW-1:0]   r_data_o, w_data_o_n;
  logic            r_data_oe, w_data_oe_n;
  logic            r_stp, w_stp_n;
  logic [7:0]      r_cnt, w_cnt_n;
  logic [7:0]      w_cnt_inc;
  logic            w_tmo;
  logic            w_ext;
  logic            w_req_illegal;
  logic [DW-1:0]   w_txcmd;
  logic            w_finish;
  logic            w_fail;

`ifdef SC_SCBC_ULPI_EXTREG_EN
  assign w_ext         = |r_addr[AW-1:6];
  assign w_req_illegal = 1'b0;
`else
  assign w_ext         = 1'b0;
  assign w_req_illegal = |ADDR[7:6];
`endif

  // Register command byte: 10 = write, 11 = read, then immediate or extended address code.
  assign w_txcmd   = {r_we ? 2'b10 : 2'b11, w_ext ? EXT_CODE : r_addr[5:0]};
  assign w_cnt_inc = (r_cnt < TMO) ? r_cnt + 8'd1 : r_cnt;
  assign w_tmo     = (w_cnt_inc >= TMO);

  always_ff @(posedge ULPICLK) begin
    if (ULPIRST) begin
      r_state   <= S_IDLE;
      r_we      <= 1'b0;
      r_addr    <= '0;
      r_wdata   <= '0;
      r_busy    <= 1'b0;
      r_ack     <= 1'b0;
      r_err     <= 1'b0;
      r_rdata   <= '0;
      r_rdbuf   <= '0;
      r_data_o  <= '0;
      r_data_oe <= 1'b0;
      r_stp     <= 1'b0;
      r_cnt     <= '0;
    end else begin
      r_state   <= w_state_n;
      r_we      <= w_we_n;
      r_addr    <= w_addr_n;
      r_wdata   <= w_wdata_n;
      r_busy    <= w_busy_n;
      r_ack     <= w_ack_n;
      r_err     <= w_err_n;
      r_rdata   <= w_rdata_n;
      r_rdbuf   <= w_rdbuf_n;
      r_data_o  <= w_data_o_n;
      r_data_oe <= w_data_oe_n;
      r_stp     <= w_stp_n;
      r_cnt     <= w_cnt_n;
    end
  end

  always_comb begin
    w_state_n   = r_state;
    w_we_n      = r_we;
    w_addr_n    = r_addr;
    w_wdata_n   = r_wdata;
    w_busy_n    = r_busy;
    w_ack_n     = 1'b0;
    w_err_n     = 1'b0;
    w_rdata_n   = r_rdata;
    w_rdbuf_n   = r_rdbuf;
    w_data_o_n  = r_data_o;
    w_data_oe_n = r_data_oe;
    w_stp_n     = 1'b0;
    w_cnt_n     = r_cnt;
    w_finish    = 1'b0;
    w_fail      = 1'b0;

    case (r_state)
      S_IDLE: begin
        if (REQ) begin
          w_we_n    = WE;
          w_addr_n  = ADDR[AW-1:0];
          w_wdata_n = WDATA;
          w_cnt_n   = '0;
          if (w_req_illegal) begin
            w_finish = 1'b1;
            w_fail   = 1'b1;
          end else begin
            w_busy_n  = 1'b1;
            w_state_n = S_WAIT_BUS;
          end
        end
      end
      S_WAIT_BUS: begin
        if (!DIR) begin
          w_state_n   = S_TXCMD;
          w_data_o_n  = w_txcmd;
          w_data_oe_n = 1'b1;
        end
      end
      // PHY abort (DIR) takes priority over NXT; the timeout budget carries across reissues.
      S_TXCMD, S_EXTADDR: begin
        w_cnt_n = w_cnt_inc;
        if (DIR) begin
          w_state_n   = S_WAIT_BUS;
          w_data_o_n  = '0;
          w_data_oe_n = 1'b0;
        end else if (NXT) begin
          if (r_state == S_TXCMD && w_ext) begin
            w_state_n  = S_EXTADDR;
            w_data_o_n = DW'(r_addr);
          end else if (r_we) begin
            w_state_n  = S_WDATA;
            w_data_o_n = r_wdata;
          end else begin
            w_state_n   = S_RD_TA;
            w_data_o_n  = '0;
            w_data_oe_n = 1'b0;
          end
        end else if (w_tmo) begin
          w_finish = 1'b1;
          w_fail   = 1'b1;
        end
      end
      S_WDATA: begin
        w_cnt_n = w_cnt_inc;
        if (DIR) begin
          w_state_n   = S_WAIT_BUS;
          w_data_o_n  = '0;
          w_data_oe_n = 1'b0;
        end else if (NXT) begin
          w_state_n  = S_STOP;
          w_stp_n    = 1'b1;
          w_data_o_n = '0;
        end else if (w_tmo) begin
          w_finish = 1'b1;
          w_fail   = 1'b1;
        end
      end
      S_STOP: w_finish = 1'b1;
      S_RD_TA: begin
        w_cnt_n = w_cnt_inc;
        if (DIR) begin
          w_state_n = S_RD_DATA;
        end else if (w_tmo) begin
          w_finish = 1'b1;
          w_fail   = 1'b1;
        end
      end
      // Read data is staged and only committed to RDATA on a successful completion.
      S_RD_DATA: begin
        if (DIR && !NXT) begin
          w_rdbuf_n = DATA_I;
          w_state_n = S_RD_TA2;
        end else if (!DIR) begin
          w_state_n = S_WAIT_BUS;
        end
      end
      S_RD_TA2: begin
        w_cnt_n = w_cnt_inc;
        if (!DIR) begin
          w_finish = 1'b1;
        end else if (w_tmo) begin
          w_finish = 1'b1;
          w_fail   = 1'b1;
        end
      end
      S_DONE:  w_state_n = S_IDLE;
      default: w_state_n = S_IDLE;
    endcase

    if (w_finish) begin
      w_state_n   = S_DONE;
      w_ack_n     = 1'b1;
      w_err_n     = w_fail;
      w_busy_n    = 1'b0;
      w_data_o_n  = '0;
      w_data_oe_n = 1'b0;
      w_stp_n     = 1'b0;
      if (!w_fail && !r_we) begin
        w_rdata_n = r_rdbuf;
      end
    end
  end

  assign BUSY    = r_busy;
  assign ACK     = r_ack;
  assign ERR     = r_err;
  assign RDATA   = r_rdata;
  assign DATA_O  = r_data_o;
  // The PHY owns the bus whenever DIR is high.
  assign DATA_OE = r_data_oe & ~DIR;
  assign STP     = r_stp;

endmodule

// File: tb/tb_sc_scbc_ulpi_reg.sv
// Self-checking bench for sc_scbc_ulpi_reg: reactive PHY model plus transaction-level expectations.
module tb_sc_scbc_ulpi_reg;

  localparam int unsigned TMO       = 8;
  localparam int          ABORT_DIR = 2;
  localparam int          BOUND     = 40;

  logic       ulpiclk = 1'b0;
  logic       ulpirst, req, we, dir, nxt;
  logic [7:0] addr, wdata, data_i;
  logic       busy, ack, err, data_oe, stp;
  logic [7:0] rdata, data_o;

  int         n_pass   = 0;
  int         n_checks = 0;
  logic [7:0] model_rdata = 8'h00;

  always #8 ulpiclk = ~ulpiclk;

  sc_scbc_ulpi_reg #(.NXT_TIMEOUT(TMO)) dut (
    .ULPICLK (ulpiclk),
    .ULPIRST (ulpirst),
    .REQ     (req),
    .WE      (we),
    .ADDR    (addr),
    .WDATA   (wdata),
    .BUSY    (busy),
    .ACK     (ack),
    .ERR     (err),
    .RDATA   (rdata),
    .DIR     (dir),
    .NXT     (nxt),
    .DATA_I  (data_i),
    .DATA_O  (data_o),
    .DATA_OE (data_oe),
    .STP     (stp)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
  endtask

  // One register access with the PHY answering each driven byte after 'stall' idle cycles.
  task automatic do_txn(input logic t_we, input logic [7:0] t_addr, input logic [7:0] t_wd,
                        input logic [7:0] t_rd, input int stall, input bit abort, input bit no_nxt);
    logic [7:0] exp_q[$];
    logic [7:0] got_q[$];
    logic [1:0] op;
    logic [5:0] code;
    logic [7:0] exp_rd;
    bit ext, illegal, exp_err, abort_left, oe_seen;
    int ncmd, exp_lat, lat, acks, stps, wait_c, rd_phase, dir_hold, abort_cyc;

    ext = |t_addr[7:6];
`ifdef SC_SCBC_ULPI_EXTREG_EN
    illegal = 1'b0;
`else
    illegal = ext;
`endif
    exp_err = illegal || no_nxt;
    ncmd    = (ext && !illegal) ? 2 : 1;
    op      = t_we ? 2'b10 : 2'b11;
    code    = ext ? 6'h2F : t_addr[5:0];
    if (!illegal) begin
      exp_q.push_back({op, code});
      if (ext) exp_q.push_back(t_addr);
      if (t_we) exp_q.push_back(t_wd);
    end
    if (no_nxt) exp_q.delete();
    if (illegal) exp_lat = 1;
    else if (no_nxt) exp_lat = 2 + int'(TMO);
    else exp_lat = (t_we ? 5 : 6) + (ncmd - 1) + stall * exp_q.size() + (abort ? 1 + ABORT_DIR : 0);
    exp_rd = (!t_we && !exp_err) ? t_rd : model_rdata;

    req = 1'b1; we = t_we; addr = t_addr; wdata = t_wd;
    lat = -1; acks = 0; stps = 0; wait_c = 0; rd_phase = 0; dir_hold = 0;
    abort_left = abort; oe_seen = 1'b0; abort_cyc = -10;

    for (int cyc = 1; cyc <= BOUND; cyc++) begin
      @(posedge ulpiclk); #1;
      if (cyc == 1) begin
        req = 1'b0;
        chk("busy_after_req", 32'(busy), 32'(!illegal));
      end
      if (cyc == abort_cyc + 1) chk("abort_oe_release", 32'(data_oe), 32'd0);
      if (data_oe) oe_seen = 1'b1;
      if (stp) begin
        stps++;
        chk("stp_data", 32'(data_o), 32'd0);
      end
      if (ack) begin
        acks++;
        if (lat < 0) begin
          lat = cyc;
          chk("err", 32'(err), 32'(exp_err));
          chk("rdata", 32'(rdata), 32'(exp_rd));
          chk("oe_at_ack", 32'(data_oe), 32'd0);
          chk("busy_at_ack", 32'(busy), 32'd0);
        end
      end
      nxt = 1'b0;
      if (dir_hold > 0) begin
        dir = 1'b1;
        dir_hold--;
      end else if (rd_phase == 1) begin
        dir = 1'b1;
        rd_phase = 2;
      end else if (rd_phase == 2) begin
        dir = 1'b1;
        data_i = t_rd;
        rd_phase = 3;
      end else begin
        dir = 1'b0;
        if (data_oe && !stp && !no_nxt) begin
          if (abort_left) begin
            abort_left = 1'b0;
            dir = 1'b1;
            dir_hold = ABORT_DIR - 1;
            abort_cyc = cyc;
          end else if (wait_c < stall) begin
            wait_c++;
          end else begin
            nxt = 1'b1;
            wait_c = 0;
            got_q.push_back(data_o);
            if (!t_we && got_q.size() == ncmd) rd_phase = 1;
          end
        end
      end
      if (lat >= 0 && cyc >= lat + 2) break;
    end

    chk("ack_seen", 32'(lat >= 0), 32'd1);
    chk("latency", 32'(lat), 32'(exp_lat));
    chk("ack_count", 32'(acks), 32'd1);
    chk("nbytes", 32'(got_q.size()), 32'(exp_q.size()));
    for (int i = 0; i < exp_q.size(); i++)
      if (i < got_q.size()) chk("tx_byte", 32'(got_q[i]), 32'(exp_q[i]));
    chk("stp_count", 32'(stps), 32'((t_we && !exp_err) ? 1 : 0));
    if (illegal) chk("oe_never", 32'(oe_seen), 32'd0);
    model_rdata = exp_rd;
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  logic       t_we;
  logic [7:0] t_addr, t_wd, t_rd;
  int         t_st, rst_acks;
  bit         t_ab, t_nn;

  initial begin
    ulpirst = 1'b1; req = 1'b0; we = 1'b0; addr = '0; wdata = '0;
    dir = 1'b0; nxt = 1'b0; data_i = '0;
    repeat (3) @(posedge ulpiclk);
    #1;
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_ack", 32'(ack), 32'd0);
    chk("rst_err", 32'(err), 32'd0);
    chk("rst_rdata", 32'(rdata), 32'd0);
    chk("rst_data_o", 32'(data_o), 32'd0);
    chk("rst_data_oe", 32'(data_oe), 32'd0);
    chk("rst_stp", 32'(stp), 32'd0);
    ulpirst = 1'b0;

    do_txn(1'b1, 8'h04, 8'h45, 8'h00, 0, 1'b0, 1'b0);
    do_txn(1'b0, 8'h0A, 8'h00, 8'h5A, 0, 1'b0, 1'b0);
    do_txn(1'b1, 8'h16, 8'hC3, 8'h00, 0, 1'b1, 1'b0);
    do_txn(1'b0, 8'h0A, 8'h00, 8'h77, 0, 1'b0, 1'b1);

    // Reset pulsed while the write data byte is on the bus.
    req = 1'b1; we = 1'b1; addr = 8'h04; wdata = 8'h33;
    @(posedge ulpiclk); #1; req = 1'b0;
    @(posedge ulpiclk); #1; nxt = 1'b1;
    @(posedge ulpiclk); #1; nxt = 1'b0;
    chk("rst_mid_wdata_phase", 32'(data_o), 32'h33);
    ulpirst = 1'b1;
    @(posedge ulpiclk); #1; ulpirst = 1'b0;
    chk("rst_mid_busy", 32'(busy), 32'd0);
    chk("rst_mid_ack", 32'(ack), 32'd0);
    chk("rst_mid_data_o", 32'(data_o), 32'd0);
    chk("rst_mid_data_oe", 32'(data_oe), 32'd0);
    chk("rst_mid_stp", 32'(stp), 32'd0);
    chk("rst_mid_rdata", 32'(rdata), 32'd0);
    rst_acks = 0;
    repeat (6) begin
      @(posedge ulpiclk); #1;
      if (ack) rst_acks++;
    end
    chk("rst_mid_no_ack", 32'(rst_acks), 32'd0);
    model_rdata = 8'h00;
    do_txn(1'b0, 8'h00, 8'h00, 8'hA5, 0, 1'b0, 1'b0);

    do_txn(1'b0, 8'h81, 8'h00, 8'h3C, 0, 1'b0, 1'b0);

    for (int t = 0; t < 40; t++) begin
      t_we   = 1'($urandom_range(0, 1));
      t_addr = 8'($urandom_range(0, 63));
      if ($urandom_range(0, 5) == 0) t_addr[7:6] = 2'($urandom_range(1, 3));
      t_wd   = 8'($urandom_range(0, 255));
      t_rd   = 8'($urandom_range(0, 255));
      t_st   = int'($urandom_range(0, 1));
      t_nn   = ($urandom_range(0, 9) == 0);
      t_ab   = !t_nn && ($urandom_range(0, 4) == 0);
      do_txn(t_we, t_addr, t_wd, t_rd, t_st, t_ab, t_nn);
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/sc_scbc_ulpi_reg.md
Name: sc_scbc_ulpi_reg

Overview:
- ULPI link-side PHY register access engine in the ULPICLK domain, downstream of the PLL lock / ULPI reset stage.
- Held in reset until the ULPI PLL is locked; ULPIRST is the inverted, locked-domain ULPIRSTB.
- Converts single-register read/write requests from the controller core into ULPI TX CMD sequences, including turnaround, NXT throttling, PHY abort (DIR) and timeout.

Parameters:
- NXT_TIMEOUT, 64: ULPICLK cycles to wait for NXT (or the read turnaround) before flagging ERR; legal range 2..255.

Ports:
- ULPICLK  in  1  ULPI 60 MHz clock; sole clock.
- ULPIRST  in  1  synchronous, active-high reset.
- REQ  in  1  request strobe; sampled only while BUSY=0.
- WE  in  1  1=write, 0=read; captured with REQ.
- ADDR  in  8  register address; only [5:0] used unless the extended feature is on.
- WDATA  in  8  write data; captured with REQ.
- BUSY  out  1  transaction in progress.
- ACK  out  1  one-cycle completion pulse.
- ERR  out  1  valid with ACK: 1=timeout or illegal address.
- RDATA  out  8  read result; valid with ACK and held until the next ACK.
- DIR  in  1  ULPI direction from the PHY.
- NXT  in  1  ULPI next from the PHY.
- DATA_I  in  8  ULPI data from the PHY.
- DATA_O  out  8  ULPI data to the PHY.
- DATA_OE  out  1  link drives DATA; forced 0 whenever DIR=1.
- STP  out  1  ULPI stop.

Behaviour:
- Interface: one clock (ULPICLK); reset (ULPIRST) is synchronous and active-high.
- Reset values: BUSY=0, ACK=0, ERR=0, RDATA=0, DATA_O=0, DATA_OE=0, STP=0, FSM=IDLE, timeout counter=0.
- Reset asserted mid-transaction: abandon immediately, no ACK is issued, and DATA_O/STP return to 0 on the next edge.
- States: IDLE, WAIT_BUS, TXCMD, WDATA, STOP, RD_TA, RD_DATA, RD_TA2, DONE.
- IDLE:
  - On REQ, capture WE/ADDR/WDATA, set BUSY=1 and go to WAIT_BUS.
  - A REQ arriving while BUSY=1 is ignored.
- WAIT_BUS:
  - While DIR=1, stay here.
  - When DIR=0, drive DATA_O={WE?2'b10:2'b11, ADDR[5:0]} with DATA_OE=1 and go to TXCMD.
- TXCMD:
  - Hold DATA_O until NXT=1 is sampled.
  - Write: on NXT, drive WDATA and go to WDATA.
  - Read: on NXT, go to RD_TA and release DATA_OE (DATA_O=0).
  - DIR=1 sampled before NXT (PHY abort): release the bus and go to WAIT_BUS, then reissue the TX CMD; the timeout counter is not cleared.
- WDATA:
  - Hold WDATA until NXT=1.
  - On NXT: STP=1 and DATA_O=0 for exactly one cycle (STOP state), then DONE.
  - DIR=1 in WDATA: abort and go to WAIT_BUS.
- RD_TA: expects DIR=1 on the next cycle (turnaround), then go to RD_DATA.
- RD_DATA: capture DATA_I into RDATA on the cycle with DIR=1 and NXT=0, then go to RD_TA2.
- RD_TA2: wait for DIR=0, then DONE.
- DONE: ACK=1 for one cycle, BUSY drops on the same edge, return to IDLE.
  - Earliest new REQ is accepted the cycle after ACK.
- Latency with no stalls, REQ to ACK:
  - Write: 5 cycles (WAIT_BUS, TXCMD, WDATA, STOP, DONE).
  - Read: 6 cycles.
- Timeout counter:
  - 8-bit; clears on entering TXCMD from IDLE/WAIT_BUS only the first time.
  - Counts every cycle in TXCMD, WDATA, RD_TA and RD_TA2.
  - Saturates at NXT_TIMEOUT; on reaching it, release the bus, go to DONE with ERR=1, and leave RDATA unchanged.
- ERR=0 on any successful ACK.

Optional Feature:
- Macro: SC_SCBC_ULPI_EXTREG_EN.
- When defined:
  - ADDR[7:6] != 0 selects extended access: TX CMD address 6'h2F.
  - After the first NXT, send ADDR as an extra byte and wait a second NXT before the data or read turnaround.
  - Adds one cycle to latency.
- When undefined:
  - ADDR[7:6] != 0 gives an immediate ACK with ERR=1 and no bus activity (IDLE→DONE).
  - ADDR=0x2F is driven as a normal immediate address.

Test Plan:
- Write 0x04←0x45, PHY asserts NXT one cycle after each driven byte -> DATA_O sequence 0x84, 0x45, then STP=1 with DATA_O=0x00; ACK with ERR=0 at cycle 5 after REQ.
- Read 0x0A, PHY returns 0x5A -> DATA_O=0xCA, DATA_OE drops after NXT, RDATA=0x5A with ACK at cycle 6, ERR=0.
- PHY raises DIR (RX CMD) in the TXCMD cycle of a write to 0x16 -> DATA_OE=0 within one cycle; 0x96 is reissued after DIR falls; single ACK, ERR=0.
- NXT never asserted, NXT_TIMEOUT=8 -> ACK with ERR=1 after 8 TXCMD cycles; DATA_OE=0; RDATA keeps its prior value.
- ULPIRST pulsed during the WDATA state -> outputs at reset values next cycle, no ACK; a following read 0x00 completes normally.
- Read ADDR=0x81: with SC_SCBC_ULPI_EXTREG_EN -> DATA_O bytes 0xEF, then 0x81; without it -> ACK with ERR=1 one cycle after REQ and DATA_OE never asserted.
